// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, byte width, divider limit and
// the mode-0 clock polarity/phase constants reused by other SPI blocks.
package spi_pkg;

  localparam int SPI_BYTE_W      = 8;
  localparam int SPI_CLK_DIV_MIN = 2;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_XFER,
    ST_HOLD,
    ST_TRAIL,
    ST_GAP
  } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// sclk half-period counter: tick fires on the CLK_DIV-th enabled cycle after
// a load or a previous tick, and the counter restarts from zero on either.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int               CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == TERM);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first, one byte per start, cs_n held across bytes
// until a byte flagged last. Define SPI_MASTER_LOOPBACK_EN to feed mosi back
// into the receive shifter in place of miso.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  last,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int               BIT_W    = $clog2(SPI_BYTE_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SPI_BYTE_W - 1);

  if (CLK_DIV < SPI_CLK_DIV_MIN) begin : g_div_check
    $error("spi_master: CLK_DIV must be at least 2");
  end

  spi_state_e            state_q, state_d;
  logic [SPI_BYTE_W-1:0] tx_sr_q, tx_sr_d;
  logic [SPI_BYTE_W-1:0] rx_sr_q, rx_sr_d;
  logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  last_q, last_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_n_q, cs_n_d;
  logic                  done_q, done_d;
  logic                  div_load;
  logic                  div_tick;
  logic                  rx_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_bit = tx_sr_q[SPI_BYTE_W-1];
`else
  assign rx_bit = miso;
`endif

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .load (div_load),
    .en   (busy),
    .tick (div_tick)
  );

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    last_d    = last_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    done_d    = 1'b0;
    div_load  = 1'b0;

    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (start) begin
          state_d   = ST_LEAD;
          tx_sr_d   = tx_data;
          last_d    = last;
          bit_cnt_d = '0;
          cs_n_d    = 1'b0;
          div_load  = 1'b1;
        end
      end

      // Leaving LEAD is the first rising sclk edge of the byte.
      ST_LEAD: begin
        if (div_tick) begin
          state_d = ST_XFER;
          sclk_d  = 1'b1;
          rx_sr_d = {rx_sr_q[SPI_BYTE_W-2:0], rx_bit};
        end
      end

      ST_XFER: begin
        if (div_tick) begin
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            rx_sr_d = {rx_sr_q[SPI_BYTE_W-2:0], rx_bit};
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt_q == LAST_BIT) begin
              done_d    = 1'b1;
              rx_data_d = rx_sr_q;
              bit_cnt_d = '0;
              state_d   = last_q ? ST_TRAIL : ST_HOLD;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              tx_sr_d   = {tx_sr_q[SPI_BYTE_W-2:0], 1'b0};
            end
          end
        end
      end

      // Clearing the shifter also returns mosi to 0 as cs_n rises.
      ST_TRAIL: begin
        if (div_tick) begin
          state_d = ST_GAP;
          cs_n_d  = 1'b1;
          tx_sr_d = '0;
        end
      end

      ST_GAP: begin
        if (div_tick) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: the shift registers are reset along with the control state so that
  // rx_data and mosi read as zero immediately after any reset, even mid-byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      last_q    <= 1'b0;
      sclk_q    <= SPI_CPOL;
      cs_n_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      last_q    <= last_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != ST_IDLE) && (state_q != ST_HOLD);
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sclk    = sclk_q;
  assign cs_n    = cs_n_q;
  assign mosi    = tx_sr_q[SPI_BYTE_W-1];

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: directed and random bytes against a
// byte-level reference (slave byte queue, cycle arithmetic), plus a CLK_DIV=2 instance.
module tb_spi_master;

  localparam int D  = 4;
  localparam int D2 = 2;

`ifdef SPI_MASTER_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, last = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       busy, done, sclk, cs_n, mosi, miso;
  logic [7:0] rx_data;

  logic       start2 = 1'b0, last2 = 1'b0;
  logic [7:0] tx2 = 8'h00;
  logic       busy2, done2, sclk2, cs_n2, mosi2;
  logic       miso2 = 1'b0;
  logic [7:0] rx2;

  int checks = 0;
  int errors = 0;
  bit in_frame = 1'b0;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(D)) u_dut (
    .clk(clk), .rst(rst), .start(start), .last(last), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk), .cs_n(cs_n),
    .mosi(mosi), .miso(miso)
  );

  spi_master #(.CLK_DIV(D2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .last(last2), .tx_data(tx2),
    .busy(busy2), .done(done2), .rx_data(rx2), .sclk(sclk2), .cs_n(cs_n2),
    .mosi(mosi2), .miso(miso2)
  );

  // Slave model: presents slave_tx MSB first, changes miso on falling sclk,
  // captures mosi on rising sclk.
  logic [7:0] slave_tx = 8'h00;
  logic [7:0] mosi_sr  = 8'h00;
  logic [2:0] bitpos   = 3'd0;
  int         rise_cnt = 0;

  always @(negedge sclk or posedge rst) begin
    if (rst) bitpos = 3'd0;
    else     bitpos = bitpos + 3'd1;
  end

  assign miso = slave_tx[3'd7 - bitpos];

  always @(posedge sclk) begin
    mosi_sr  = {mosi_sr[6:0], mosi};
    rise_cnt = rise_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_byte(input logic [7:0] tx, input logic lst,
                          input logic [7:0] sb, input bit inject);
    int n, done_at, cs_hi_at, idle_at, n_done;
    logic [7:0] exp_rx;
    exp_rx   = LOOPBACK ? tx : sb;
    slave_tx = sb;
    @(negedge clk);
    check("pre_start_cs_n", {31'd0, cs_n}, in_frame ? 32'd0 : 32'd1);
    start = 1'b1; tx_data = tx; last = lst;
    n = 0; done_at = -1; cs_hi_at = -1; idle_at = -1; n_done = 0;
    while (n < 40 * D) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0; tx_data = 8'($urandom); last = 1'($urandom);
        check("accept_busy", {31'd0, busy}, 32'd1);
        check("accept_cs_n", {31'd0, cs_n}, 32'd0);
        check("accept_mosi", {31'd0, mosi}, {31'd0, tx[7]});
      end
      if (inject && n == 6 * D) begin
        start = 1'b1; tx_data = 8'hFF; last = 1'b1;
      end
      if (inject && n == 6 * D + 1) start = 1'b0;
      if (done) begin
        n_done++;
        if (done_at < 0) begin
          done_at = n;
          check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx});
          check("mosi_stream", {24'd0, mosi_sr}, {24'd0, tx});
        end
      end
      if (cs_n && cs_hi_at < 0) cs_hi_at = n;
      if (done && !lst) begin
        check("hold_busy", {31'd0, busy}, 32'd0);
        check("hold_cs_n", {31'd0, cs_n}, 32'd0);
        check("hold_mosi", {31'd0, mosi}, {31'd0, tx[0]});
        break;
      end
      if (lst && !busy) begin
        idle_at = n;
        break;
      end
    end
    check("done_cycle", done_at, 16 * D + 1);
    check("done_count", n_done, 1);
    if (lst) begin
      check("cs_n_rise_cycle", cs_hi_at, 17 * D + 1);
      check("idle_cycle", idle_at, 18 * D + 1);
    end else begin
      check("cs_n_low_in_frame", cs_hi_at, -1);
    end
    in_frame = !lst;
  endtask

  initial begin
    int base, n, prev_rise, n2_done, hi_cnt;
    logic prev_sclk2, seen_done;
    logic [7:0] b2;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sclk", {31'd0, sclk}, 32'd0);
    check("rst_cs_n", {31'd0, cs_n}, 32'd1);
    check("rst_mosi", {31'd0, mosi}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_cs_n2", {31'd0, cs_n2}, 32'd1);
    rst = 1'b0;

    // Single byte, last=1
    run_byte(8'hA5, 1'b1, 8'h3C, 1'b0);
    // Two-byte frame, second start the cycle after the first done
    run_byte(8'h12, 1'b0, 8'hAB, 1'b0);
    run_byte(8'h34, 1'b1, 8'hCD, 1'b0);
    // Start pulsed mid-transfer is ignored
    run_byte(8'h96, 1'b1, 8'h5E, 1'b1);
    // miso held high (loopback build must still return tx)
    run_byte(8'h5A, 1'b1, 8'hFF, 1'b0);

    // Reset at the 4th rising sclk edge
    slave_tx = 8'h66;
    @(negedge clk);
    start = 1'b1; tx_data = 8'hC3; last = 1'b1;
    base = rise_cnt;
    for (int i = 0; i < 20 * D; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (rise_cnt - base == 4) break;
    end
    check("rst_test_reached_rise4", rise_cnt - base, 4);
    rst = 1'b1;
    #1;
    check("midrst_sclk", {31'd0, sclk}, 32'd0);
    check("midrst_cs_n", {31'd0, cs_n}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_mosi", {31'd0, mosi}, 32'd0);
    check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_frame = 1'b0;
    run_byte(8'h81, 1'b1, 8'h7E, 1'b0);

    // Random bytes and frames
    for (int i = 0; i < 6; i++) begin
      run_byte(8'($urandom), (i == 5) ? 1'b1 : 1'($urandom), 8'($urandom), 1'b0);
    end

    // CLK_DIV=2 instance: 0x00 then 0xFF, each closing its frame
    n2_done = 0;
    hi_cnt  = 0;
    for (int k = 0; k < 2; k++) begin
      b2 = (k == 0) ? 8'h00 : 8'hFF;
      @(negedge clk);
      start2 = 1'b1; tx2 = b2; last2 = 1'b1;
      n = 0; prev_rise = -1; prev_sclk2 = sclk2; seen_done = 1'b0;
      while (n < 40 * D2) begin
        @(negedge clk);
        n++;
        if (n == 1) start2 = 1'b0;
        if (sclk2 && !prev_sclk2) begin
          if (prev_rise >= 0) check("d2_sclk_period", n - prev_rise, 2 * D2);
          prev_rise = n;
        end
        prev_sclk2 = sclk2;
        if (done2) begin
          n2_done++;
          seen_done = 1'b1;
          check("d2_rx_data", {24'd0, rx2}, LOOPBACK ? {24'd0, b2} : 32'd0);
        end
        if (k == 0 && seen_done && cs_n2) hi_cnt++;
        if (!busy2) break;
      end
      check("d2_finished", {31'd0, busy2}, 32'd0);
    end
    check("d2_cs_n_high_min", {31'd0, hi_cnt >= D2}, 32'd1);
    check("d2_done_count", n2_done, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI mode-0 master (CPOL=0, CPHA=0), MSB first, one 8-bit byte per start request.
- Drives sclk/cs_n/mosi toward the peripheral-side SPI slave bridge and samples its miso.
- Used by the test harness and the on-chip configuration sequencer to read and write PWM-generator registers over SPI.
- Multi-byte frames: cs_n stays low between bytes until a byte is flagged last.

Parameters:
- CLK_DIV, 4: sclk half-period in clk cycles; legal minimum 2. sclk frequency = clk/(2*CLK_DIV).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request one byte transfer; accepted only when busy=0.
- last  input  1  sampled with an accepted start; 1 = deassert cs_n after this byte.
- tx_data  input  8  byte to send; sampled with an accepted start.
- busy  output  1  transfer in progress or cs_n release/gap pending.
- done  output  1  one-cycle pulse when a byte completes.
- rx_data  output  8  last received byte; valid from the done cycle and held until the next done.
- sclk  output  1  SPI clock, idle low.
- cs_n  output  1  chip select, active low.
- mosi  output  1  master out.
- miso  input  1  master in.

Behaviour:
- Reset (asynchronous, immediate, including mid-transfer): sclk=0, cs_n=1, mosi=0, busy=0, done=0, rx_data=0x00; FSM returns to IDLE; divider and bit counter are cleared.
- FSM states: IDLE, LEAD, XFER, HOLD (cs_n low, awaiting the next byte), TRAIL, GAP.
- Start acceptance:
  - A start sampled high in IDLE or HOLD at edge T is accepted.
  - At T+1: busy=1, cs_n=0, mosi=tx_data[7], tx/last latched; FSM enters LEAD.
  - Start while busy=1 is ignored; there is no queueing.
- LEAD: lasts CLK_DIV cycles, then enters XFER.
- XFER: sclk toggles every CLK_DIV cycles.
  - First rising edge at T+1+CLK_DIV.
  - On the cycle sclk goes 1: sample miso into the rx shift register (LSB-in).
  - On the cycle sclk goes 0: advance the bit counter (0..7) and drive the next tx bit on mosi.
- Byte completion, on the 8th falling edge (T+1+16*CLK_DIV):
  - rx_data updated; done=1 for that cycle.
  - last=0: enter HOLD; busy=0 that same cycle; cs_n stays 0; mosi holds bit 0.
  - last=1: enter TRAIL; busy stays 1.
- TRAIL: lasts CLK_DIV cycles. At its end cs_n=1 and mosi=0 (T+1+17*CLK_DIV); FSM enters GAP.
- GAP: lasts CLK_DIV cycles with cs_n high. Then IDLE with busy=0 (T+1+18*CLK_DIV).
- HOLD: a new start behaves as from IDLE, except cs_n is already 0; the LEAD phase still provides MOSI setup time. There is no timeout; HOLD persists until a start arrives or reset.
- Timing invariants:
  - sclk is low in all states except during XFER high phases.
  - Minimum cs_n high time = CLK_DIV cycles.
- miso is sampled without a synchronizer. The slave changes miso on falling sclk, giving CLK_DIV cycles of setup margin. CLK_DIV≥2 is required and is checked by elaboration assertion.
- Divider counter width = clog2(CLK_DIV). It reloads at each sclk toggle and each state entry.

Optional Feature:
- SPI_MASTER_LOOPBACK_EN.
- Defined: the rx shift register samples the internally driven mosi instead of miso, and the miso port is ignored. rx_data equals tx_data at each done. All pin-level timing is unchanged.
- Undefined: miso is sampled as specified above.

Decomposition:
- Shared package spi_pkg:
  - FSM state enum.
  - SPI_BYTE_W=8.
  - SPI_CLK_DIV_MIN=2.
  - mode-0 CPOL/CPHA constants, shared with future SPI blocks.
- One sub-module, spi_clk_div: half-period counter with load/enable inputs and a tick output.
- FSM, shift registers and bit counter live in spi_master.

Test Plan:
- CLK_DIV=4, start at T with tx_data=0xA5, last=1; slave model returns 0x3C -> mosi bits at rising sclk 1,0,1,0,0,1,0,1; rx_data=0x3C with done at T+65; cs_n high at T+69; busy low at T+73.
- Two-byte frame, 0x12 (last=0) then 0x34 (last=1) started the cycle after the first done -> cs_n never rises between bytes; two done pulses; rx_data matches both slave bytes.
- Start pulsed during XFER with tx_data=0xFF -> ignored; mosi stream and rx_data of the current byte unaffected; no extra done.
- rst asserted at the 4th rising sclk edge -> same cycle: sclk=0, cs_n=1, busy=0, rx_data=0x00; next start completes a normal byte.
- CLK_DIV=2, tx 0x00 and 0xFF back-to-back with last=1 each -> sclk period exactly 4 clk; cs_n high ≥2 cycles between bytes; slave bridge byte_sync fires twice with matching data_in.
- SPI_MASTER_LOOPBACK_EN defined, miso tied 1, tx 0x5A -> rx_data=0x5A.
